// File: rtl/i2s_tone_sequencer.sv
// i2s_tone_sequencer
//
// Drives the tone lookup ROM (sine / triangle) and turns each fetched entry into a paced stereo
// sample word for the I2S transmit FIFO writer. On every sample-rate tick one table entry is
// fetched, arithmetically attenuated, and offered as {left, right} on a valid/ready handshake.
// The table position advances only once the consumer has accepted the word.
//
// Parameters
//   MUTE_RIGHT     1: right channel forced to zero, 0: right channel mirrors left
//   OVR_WIDTH      width of the saturating overrun counter
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   enable         run request; falling enable stops at the next safe point
//   tone_sel       requested table (0 sine, 1 triangle), taken only at a period boundary
//   attenuate      arithmetic right-shift amount applied to the fetched entry
//   sample_tick    one-cycle strobe at the audio sample rate
//   wave_sel       table select to the ROM
//   wave_pos       table index to the ROM
//   wave_len       period length returned by the ROM
//   wave_value     signed entry returned by the ROM (combinational from wave_sel/wave_pos)
//   out_data       {left[15:0], right[15:0]}
//   out_valid      out_data holds a sample
//   out_ready      consumer accepts out_data when out_valid & out_ready
//   overrun_count  ticks dropped because a sample was still pending (saturating)
//   busy           sequencer is not idle

`timescale 1ns/1ps

module i2s_tone_sequencer #(
  parameter bit          MUTE_RIGHT = 1'b0,
  parameter int unsigned OVR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 tone_sel,
  input  logic [3:0]           attenuate,
  input  logic                 sample_tick,
  output logic                 wave_sel,
  output logic [7:0]           wave_pos,
  input  logic [7:0]           wave_len,
  input  logic [15:0]          wave_value,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OVR_WIDTH-1:0] overrun_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    StIdle,
    StWaitTick,
    StLookup,
    StOffer
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            pos_q, pos_d;
  logic                  sel_q, sel_d;
  logic [31:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic [OVR_WIDTH-1:0]  ovr_q, ovr_d;

  logic [8:0]            pos_inc;
  logic                  pos_wrap;
  logic signed [15:0]    sample_s;
  logic [15:0]           right_s;
  logic                  tick_drop;
  logic                  accept;

  // 9-bit increment so a position of 255 cannot alias to 0; the >= compare also pulls an
  // out-of-range position back to the start of the table.
  assign pos_inc  = {1'b0, pos_q} + 9'd1;
  assign pos_wrap = (pos_inc >= {1'b0, wave_len});

  assign sample_s = $signed(wave_value) >>> attenuate;
  assign right_s  = MUTE_RIGHT ? 16'h0000 : $unsigned(sample_s);

  // A tick that arrives while a sample is being fetched or still pending is lost.
  assign tick_drop = sample_tick && ((state_q == StLookup) || (state_q == StOffer));
  assign accept    = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (tick_drop && !(&ovr_q)) begin
      ovr_d = ovr_q + OVR_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        pos_d = 8'd0;
        if (enable) begin
          sel_d   = tone_sel;
          state_d = StWaitTick;
        end
      end

      StWaitTick: begin
        if (!enable) begin
          pos_d   = 8'd0;
          state_d = StIdle;
        end else if (sample_tick) begin
          state_d = StLookup;
        end
      end

      StLookup: begin
        data_d  = {sample_s, right_s};
        valid_d = 1'b1;
        state_d = StOffer;
      end

      StOffer: begin
        // Hold the word until accepted, even if enable has dropped meanwhile.
        if (accept) begin
          valid_d = 1'b0;
          if (pos_wrap) begin
            pos_d = 8'd0;
            sel_d = tone_sel;
          end else begin
            pos_d = pos_inc[7:0];
          end
          if (enable) begin
            state_d = StWaitTick;
          end else begin
            pos_d   = 8'd0;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pos_q   <= 8'd0;
      sel_q   <= 1'b0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign wave_sel      = sel_q;
  assign wave_pos      = pos_q;
  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign overrun_count = ovr_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_tone_sequencer.sv
// Self-checking bench for i2s_tone_sequencer. Two instances run in lockstep on the same stimulus:
// one with the right channel mirrored, one with it muted. Each has its own behavioural ROM.
// Expected samples are queued when a tick is issued and popped when the word is accepted.

`timescale 1ns/1ps

module tb_i2s_tone_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        tone_sel;
  logic [3:0]  attenuate;
  logic        sample_tick;
  logic        out_ready;

  logic        wave_sel, m_wave_sel;
  logic [7:0]  wave_pos, m_wave_pos;
  logic [7:0]  wave_len, m_wave_len;
  logic [15:0] wave_value, m_wave_value;
  logic [31:0] out_data, m_out_data;
  logic        out_valid, m_out_valid;
  logic [7:0]  overrun_count, m_overrun_count;
  logic        busy, m_busy;

  logic [15:0] sine_tab [0:63];

  int          n_checks;
  int          n_fail;
  logic [15:0] sb_q [$];

  // Reference model of the table position
  logic [7:0]  exp_pos;
  logic        exp_sel;

  i2s_tone_sequencer #(
    .MUTE_RIGHT (1'b0),
    .OVR_WIDTH  (8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .tone_sel      (tone_sel),
    .attenuate     (attenuate),
    .sample_tick   (sample_tick),
    .wave_sel      (wave_sel),
    .wave_pos      (wave_pos),
    .wave_len      (wave_len),
    .wave_value    (wave_value),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun_count (overrun_count),
    .busy          (busy)
  );

  i2s_tone_sequencer #(
    .MUTE_RIGHT (1'b1),
    .OVR_WIDTH  (8)
  ) u_dut_mute (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .tone_sel      (tone_sel),
    .attenuate     (attenuate),
    .sample_tick   (sample_tick),
    .wave_sel      (m_wave_sel),
    .wave_pos      (m_wave_pos),
    .wave_len      (m_wave_len),
    .wave_value    (m_wave_value),
    .out_data      (m_out_data),
    .out_valid     (m_out_valid),
    .out_ready     (out_ready),
    .overrun_count (m_overrun_count),
    .busy          (m_busy)
  );

  // Behavioural waveform ROMs: 44-entry sine, 16-entry ramp 0..15
  assign wave_len   = wave_sel ? 8'd16 : 8'd44;
  assign m_wave_len = m_wave_sel ? 8'd16 : 8'd44;

  always_comb begin
    wave_value = 16'h0000;
    if (wave_sel) begin
      if (wave_pos < 8'd16) wave_value = {8'h00, wave_pos};
    end else if (wave_pos < 8'd44) begin
      wave_value = sine_tab[wave_pos[5:0]];
    end
  end

  always_comb begin
    m_wave_value = 16'h0000;
    if (m_wave_sel) begin
      if (m_wave_pos < 8'd16) m_wave_value = {8'h00, m_wave_pos};
    end else if (m_wave_pos < 8'd44) begin
      m_wave_value = sine_tab[m_wave_pos[5:0]];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rom_val(input logic sel, input logic [7:0] pos);
    if (sel) return (pos < 8'd16) ? {8'h00, pos} : 16'h0000;
    return (pos < 8'd44) ? sine_tab[pos[5:0]] : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_sample(input logic sel, input logic [7:0] pos,
                                             input logic [3:0] att);
    logic signed [15:0] v;
    v = rom_val(sel, pos);
    return v >>> att;
  endfunction

  // Raise a one-cycle tick on a falling edge and queue the word it should produce.
  task automatic launch_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    sb_q.push_back(exp_sample(exp_sel, exp_pos, attenuate));
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Called one falling edge after the tick was raised; valid must appear on the second.
  task automatic wait_valid(output bit ok);
    int lat;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    ok = out_valid;
    check_eq("valid_latency", lat, 2);
    if (!ok && sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  // Accept the offered word (optionally with a coincident tick) and step the position model.
  task automatic accept_word(input bit with_tick, output logic [31:0] d_main,
                             output logic [31:0] d_mute);
    logic [15:0] s;
    logic [8:0]  nxt;
    out_ready = 1'b1;
    if (with_tick) sample_tick = 1'b1;
    d_main = out_data;
    d_mute = m_out_data;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      s = sb_q.pop_front();
      check_eq("word_stereo", out_data, {s, s});
      check_eq("word_muted", m_out_data, {s, 16'h0000});
      check_eq("mute_valid", m_out_valid, 1'b1);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    nxt = {1'b0, exp_pos} + 9'd1;
    if (nxt >= (exp_sel ? 9'd16 : 9'd44)) begin
      exp_pos = 8'd0;
      exp_sel = tone_sel;
    end else begin
      exp_pos = nxt[7:0];
    end
    if (!enable) exp_pos = 8'd0;
    check_eq("valid_cleared", out_valid, 1'b0);
    check_eq("wave_pos", wave_pos, exp_pos);
    check_eq("wave_sel", wave_sel, exp_sel);
    check_eq("mute_wave_sel", m_wave_sel, exp_sel);
  endtask

  task automatic run_sample(output logic [31:0] d_main, output logic [31:0] d_mute);
    bit ok;
    launch_tick();
    wait_valid(ok);
    if (ok) begin
      accept_word(1'b0, d_main, d_mute);
    end else begin
      d_main = 'x;
      d_mute = 'x;
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  initial begin
    real         v;
    logic [31:0] dm, dmm;
    logic [15:0] held;
    bit          ok;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) begin
      sine_tab[i] = 16'h0000;
    end
    for (int i = 0; i < 44; i++) begin
      v = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 44.0);
      v = (v >= 0.0) ? v + 1.0e-6 : v - 1.0e-6;
      sine_tab[i] = 16'($rtoi(v));
    end

    rst_n       = 1'b0;
    enable      = 1'b0;
    tone_sel    = 1'b0;
    attenuate   = 4'd0;
    sample_tick = 1'b0;
    out_ready   = 1'b1;
    exp_pos     = 8'd0;
    exp_sel     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_overrun", overrun_count, 8'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_wave_pos", wave_pos, 8'd0);
    check_eq("rst_wave_sel", wave_sel, 1'b0);
    check_eq("rst_mute_pos", m_wave_pos, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sine period plus wrap, unattenuated
    enable  = 1'b1;
    exp_sel = tone_sel;
    for (int w = 1; w <= 46; w++) begin
      run_sample(dm, dmm);
      if (w == 1)  check_eq("word1", dm, 32'h00000000);
      if (w == 2)  check_eq("word2", dm, 32'h12371237);
      if (w == 3)  check_eq("word3", dm, 32'h240F240F);
      if (w == 12) check_eq("word12", dm, 32'h7FFF7FFF);
      if (w == 34) check_eq("word34", dm, 32'h80018001);
      if (w == 45) check_eq("word45_wrap", dm, 32'h00000000);
    end

    // Drop enable while waiting for a tick
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_eq("wait_stop_busy", busy, 1'b0);
    check_eq("wait_stop_mute_busy", m_busy, 1'b0);
    check_eq("wait_stop_pos", wave_pos, 8'd0);
    exp_pos = 8'd0;

    // Attenuation, including sign preservation
    attenuate = 4'd4;
    enable    = 1'b1;
    exp_sel   = tone_sel;
    for (int w = 0; w < 12; w++) begin
      run_sample(dm, dmm);
    end
    check_eq("mute_att4_idx11", dmm, 32'h07FF0000);
    attenuate = 4'd1;
    for (int w = 12; w < 34; w++) begin
      run_sample(dm, dmm);
    end
    check_eq("mute_att1_idx33", dmm, 32'hC0000000);
    attenuate = 4'd0;

    // Table switch requested mid-period takes effect only at the wrap
    for (int w = 34; w < 44 + 5; w++) begin
      run_sample(dm, dmm);
    end
    check_eq("pre_switch_pos", wave_pos, 8'd5);
    tone_sel = 1'b1;
    for (int w = 5; w < 44; w++) begin
      run_sample(dm, dmm);
    end
    for (int w = 0; w < 32; w++) begin
      run_sample(dm, dmm);
      if (w == 15) check_eq("tri_idx15", dm, 32'h000F000F);
      if (w == 16) check_eq("tri_wrap", dm, 32'h00000000);
    end

    // Backpressure: three dropped ticks, release coincident with a fourth
    out_ready = 1'b0;
    launch_tick();
    wait_valid(ok);
    held = (sb_q.size() > 0) ? sb_q[0] : 16'hxxxx;
    pulse_ticks(3);
    check_eq("hold_data", out_data, {held, held});
    check_eq("hold_valid", out_valid, 1'b1);
    check_eq("overrun3", overrun_count, 8'd3);
    accept_word(1'b1, dm, dmm);
    check_eq("overrun4_on_accept", overrun_count, 8'd4);
    repeat (5) @(negedge clk);
    check_eq("no_restart_after_drop", out_valid, 1'b0);

    // Saturation of the overrun counter
    out_ready = 1'b0;
    launch_tick();
    wait_valid(ok);
    held = (sb_q.size() > 0) ? sb_q[0] : 16'hxxxx;
    pulse_ticks(300);
    check_eq("overrun_sat", overrun_count, 8'hFF);
    check_eq("mute_overrun_sat", m_overrun_count, 8'hFF);
    check_eq("sat_hold_data", out_data, {held, held});
    accept_word(1'b0, dm, dmm);
    repeat (4) @(negedge clk);

    // Enable falls while a word is pending: word survives, then idle
    out_ready = 1'b0;
    launch_tick();
    wait_valid(ok);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("offer_kept_valid", out_valid, 1'b1);
    check_eq("offer_kept_busy", busy, 1'b1);
    accept_word(1'b0, dm, dmm);
    check_eq("offer_stop_busy", busy, 1'b0);
    check_eq("offer_stop_pos", wave_pos, 8'd0);

    // Asynchronous reset in the middle of an offer
    enable    = 1'b1;
    exp_sel   = tone_sel;
    exp_pos   = 8'd0;
    out_ready = 1'b0;
    launch_tick();
    wait_valid(ok);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", out_valid, 1'b0);
    check_eq("async_data", out_data, 32'h0);
    check_eq("async_pos", wave_pos, 8'd0);
    check_eq("async_overrun", overrun_count, 8'd0);
    sb_q.delete();
    tone_sel = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_pos   = 8'd0;
    exp_sel   = 1'b0;
    run_sample(dm, dmm);
    check_eq("restart_word", dm, 32'h00000000);
    run_sample(dm, dmm);
    check_eq("restart_word2", dm, 32'h12371237);

    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
